// File: rtl/xgmii_rx_link_monitor.sv
// XGMII receive link monitor: decodes control characters on the 64-bit RX word,
// tracks link fault ordered sets, debounces link_up and keeps frame statistics.
module xgmii_rx_link_monitor #(
  parameter int LINK_UP_CYCLES    = 1024,
  parameter int FAULT_SET_COUNT   = 4,
  parameter int FAULT_CLEAR_COUNT = 128,
  parameter int COUNT_WIDTH       = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [63:0]            xgmii_rxd,
  input  logic [7:0]             xgmii_rxc,
  input  logic                   rx_block_lock,
  input  logic                   clear_counters,
  output logic                   link_up,
  output logic                   local_fault,
  output logic                   remote_fault,
  output logic [COUNT_WIDTH-1:0] frame_count,
  output logic [COUNT_WIDTH-1:0] bad_frame_count,
  output logic [COUNT_WIDTH-1:0] fault_event_count
);

  localparam int RW  = $clog2(FAULT_SET_COUNT + 1);
  localparam int CLW = $clog2(FAULT_CLEAR_COUNT + 1);
  localparam int QW  = (LINK_UP_CYCLES > 2) ? $clog2(LINK_UP_CYCLES) : 1;

  localparam logic [RW-1:0]  RUN_SET    = RW'(FAULT_SET_COUNT);
  localparam logic [CLW-1:0] CLEAN_DONE = CLW'(FAULT_CLEAR_COUNT);
  localparam logic [QW-1:0]  QUAL_LAST  = QW'(LINK_UP_CYCLES - 1);

  typedef enum logic [1:0] {
    LINK_DOWN    = 2'd0,
    LINK_QUALIFY = 2'd1,
    LINK_UP      = 2'd2
  } link_state_t;

  typedef enum logic {
    FR_IDLE     = 1'b0,
    FR_IN_FRAME = 1'b1
  } frame_state_t;

  // One half of the word carries an ordered set: 0x9C control, then 00,00,<code> data.
  function automatic logic fault_os(input logic [31:0] d, input logic [3:0] c,
                                    input logic [7:0] code);
    return (c == 4'b0001) && (d[7:0] == 8'h9C) && (d[31:8] == {code, 16'h0000});
  endfunction

  function automatic logic [COUNT_WIDTH-1:0] sat_next(input logic [COUNT_WIDTH-1:0] v,
                                                     input logic inc, input logic clr);
    if (clr)
      return '0;
    else if (inc && (v != '1))
      return v + COUNT_WIDTH'(1);
    else
      return v;
  endfunction

  // ---------------------------------------------------------------- decode
  logic is_start0, is_start4, is_start;
  logic is_term, is_term_lo, is_err;
  logic word_local, word_remote, word_fault;

  always_comb begin
    is_term    = 1'b0;
    is_term_lo = 1'b0;
    is_err     = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (xgmii_rxc[k] && (xgmii_rxd[8*k +: 8] == 8'hFD)) begin
        is_term = 1'b1;
        if (k < 4) is_term_lo = 1'b1;
      end
      if (xgmii_rxc[k] && (xgmii_rxd[8*k +: 8] == 8'hFE)) is_err = 1'b1;
    end
  end

  assign is_start0   = xgmii_rxc[0] && (xgmii_rxd[7:0] == 8'hFB);
  assign is_start4   = xgmii_rxc[4] && (xgmii_rxd[39:32] == 8'hFB);
  assign is_start    = is_start0 || is_start4;
  assign word_local  = fault_os(xgmii_rxd[31:0], xgmii_rxc[3:0], 8'h01) ||
                       fault_os(xgmii_rxd[63:32], xgmii_rxc[7:4], 8'h01);
  assign word_remote = fault_os(xgmii_rxd[31:0], xgmii_rxc[3:0], 8'h02) ||
                       fault_os(xgmii_rxd[63:32], xgmii_rxc[7:4], 8'h02);
  assign word_fault  = word_local || word_remote;

  // ---------------------------------------------------------------- fault tracking
  logic           local_q, remote_q, local_nxt, remote_nxt;
  logic           run_local_q, run_local_nxt;
  logic [RW-1:0]  run_cnt_q, run_cnt_nxt;
  logic [CLW-1:0] clean_cnt_q, clean_cnt_nxt;
  logic           fault_rise;

  always_comb begin
    local_nxt     = local_q;
    remote_nxt    = remote_q;
    run_local_nxt = run_local_q;
    run_cnt_nxt   = run_cnt_q;
    clean_cnt_nxt = clean_cnt_q;
    if (!rx_block_lock) begin
      local_nxt     = 1'b0;
      remote_nxt    = 1'b0;
      run_cnt_nxt   = '0;
      clean_cnt_nxt = '0;
    end else if (!word_fault) begin
      run_cnt_nxt   = '0;
      clean_cnt_nxt = (clean_cnt_q == CLEAN_DONE) ? CLEAN_DONE : clean_cnt_q + CLW'(1);
      if (clean_cnt_nxt == CLEAN_DONE) begin
        local_nxt  = 1'b0;
        remote_nxt = 1'b0;
      end
    end else begin
      // Local wins when both ordered sets share one word.
      clean_cnt_nxt = '0;
      run_local_nxt = word_local;
      if ((run_cnt_q != '0) && (run_local_q == word_local))
        run_cnt_nxt = (run_cnt_q == RUN_SET) ? RUN_SET : run_cnt_q + RW'(1);
      else
        run_cnt_nxt = RW'(1);
      if (run_cnt_nxt >= RUN_SET) begin
        local_nxt  = word_local;
        remote_nxt = !word_local;
      end
    end
  end

  assign fault_rise = (local_nxt && !local_q) || (remote_nxt && !remote_q);

  // ---------------------------------------------------------------- link FSM
  link_state_t   link_state_q, link_state_nxt;
  logic [QW-1:0] qual_cnt_q, qual_cnt_nxt;
  logic          link_clean;

  assign link_clean = rx_block_lock && !(local_nxt || remote_nxt);

  always_comb begin
    link_state_nxt = link_state_q;
    qual_cnt_nxt   = qual_cnt_q;
    case (link_state_q)
      LINK_DOWN: begin
        if (link_clean) begin
          link_state_nxt = LINK_QUALIFY;
          qual_cnt_nxt   = '0;
        end
      end
      LINK_QUALIFY: begin
        if (!link_clean)
          link_state_nxt = LINK_DOWN;
        else if (qual_cnt_q == QUAL_LAST)
          link_state_nxt = LINK_UP;
        else
          qual_cnt_nxt = qual_cnt_q + QW'(1);
      end
      LINK_UP: begin
        if (!link_clean) link_state_nxt = LINK_DOWN;
      end
      default: link_state_nxt = LINK_DOWN;
    endcase
  end

  // ---------------------------------------------------------------- frame FSM
  frame_state_t frame_state_q, frame_state_nxt;
  logic         errored_q, errored_nxt;
  logic         good_inc, bad_inc;

  always_comb begin
    frame_state_nxt = frame_state_q;
    errored_nxt     = errored_q;
    good_inc        = 1'b0;
    bad_inc         = 1'b0;
    if (!rx_block_lock) begin
      bad_inc         = (frame_state_q == FR_IN_FRAME);
      frame_state_nxt = FR_IDLE;
      errored_nxt     = 1'b0;
    end else begin
      case (frame_state_q)
        FR_IDLE: begin
          if (is_start) begin
            frame_state_nxt = FR_IN_FRAME;
            errored_nxt     = 1'b0;
          end
        end
        FR_IN_FRAME: begin
          // Terminate in the low half closes the old frame before a lane-4 start opens a new one.
          if (is_term_lo && is_start4) begin
            good_inc    = !(errored_q || is_err);
            bad_inc     = errored_q || is_err;
            errored_nxt = 1'b0;
          end else if (is_start) begin
            bad_inc     = 1'b1;
            errored_nxt = 1'b0;
          end else if (is_term) begin
            good_inc        = !(errored_q || is_err);
            bad_inc         = errored_q || is_err;
            frame_state_nxt = FR_IDLE;
            errored_nxt     = 1'b0;
          end else if (is_err) begin
            errored_nxt = 1'b1;
          end
        end
        default: frame_state_nxt = FR_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- registers
  logic [COUNT_WIDTH-1:0] frame_cnt_q, bad_cnt_q, event_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      local_q       <= 1'b0;
      remote_q      <= 1'b0;
      run_local_q   <= 1'b0;
      run_cnt_q     <= '0;
      clean_cnt_q   <= '0;
      link_state_q  <= LINK_DOWN;
      qual_cnt_q    <= '0;
      frame_state_q <= FR_IDLE;
      errored_q     <= 1'b0;
      frame_cnt_q   <= '0;
      bad_cnt_q     <= '0;
      event_cnt_q   <= '0;
    end else begin
      local_q       <= local_nxt;
      remote_q      <= remote_nxt;
      run_local_q   <= run_local_nxt;
      run_cnt_q     <= run_cnt_nxt;
      clean_cnt_q   <= clean_cnt_nxt;
      link_state_q  <= link_state_nxt;
      qual_cnt_q    <= qual_cnt_nxt;
      frame_state_q <= frame_state_nxt;
      errored_q     <= errored_nxt;
      frame_cnt_q   <= sat_next(frame_cnt_q, good_inc, clear_counters);
      bad_cnt_q     <= sat_next(bad_cnt_q, bad_inc, clear_counters);
      event_cnt_q   <= sat_next(event_cnt_q, fault_rise, clear_counters);
    end
  end

  assign link_up           = (link_state_q == LINK_UP);
  assign local_fault       = local_q;
  assign remote_fault      = remote_q;
  assign frame_count       = frame_cnt_q;
  assign bad_frame_count   = bad_cnt_q;
  assign fault_event_count = event_cnt_q;

endmodule

// File: doc/xgmii_rx_link_monitor.md
Name: xgmii_rx_link_monitor

Overview:
- Per-lane XGMII receive monitor. Sits directly downstream of each 10GBASE-R PHY RX output (64-bit XGMII data/control plus block lock), in the PHY RX clock domain.
- Tracks link fault ordered sets and produces a debounced link_up.
- Delimits frames and keeps saturating good, bad and fault statistics for the core and debug logic.

Parameters:
- LINK_UP_CYCLES, 1024: consecutive clean cycles (block lock, no fault) required before link_up asserts.
- FAULT_SET_COUNT, 4: consecutive words carrying the same fault ordered set needed to declare a fault.
- FAULT_CLEAR_COUNT, 128: consecutive words with no fault ordered set needed to clear a declared fault.
- COUNT_WIDTH, 32: width of the statistics counters.

Ports:
- clk  in  1  PHY RX clock (156.25 MHz)
- rst  in  1  asynchronous, active-high reset
- xgmii_rxd  in  64  XGMII RX data; lane k = bits [8k+7:8k]
- xgmii_rxc  in  8  XGMII RX control; bit k qualifies lane k
- rx_block_lock  in  1  PHY block lock
- clear_counters  in  1  synchronous one-cycle pulse; zeroes all statistics counters
- link_up  out  1  debounced link status
- local_fault  out  1  local fault currently declared
- remote_fault  out  1  remote fault currently declared
- frame_count  out  COUNT_WIDTH  good frames received
- bad_frame_count  out  COUNT_WIDTH  errored or aborted frames
- fault_event_count  out  COUNT_WIDTH  number of fault declarations (rising edges of local_fault or remote_fault)

Behaviour:
- Reset: all outputs 0, both FSMs in their initial state, all counters 0.
- Latency: every output is registered and reflects the input word 1 cycle later.
- Character decode (control lane only):
  - Start = 0xFB in lane 0 or lane 4.
  - Terminate = 0xFD in any lane.
  - Error = 0xFE in any lane.
  - Fault ordered set = 0x9C in lane 0 (or lane 4), with the next three lanes data. Those lanes hold 00,00,01 for local fault or 00,00,02 for remote fault.
- Fault tracking:
  - A local-fault word is any word containing a local ordered set. Remote-fault words are defined the same way.
  - fault_run counter increments on consecutive words of the same type. It reloads to 1 when the type changes and clears on a word with no fault set.
  - Reaching FAULT_SET_COUNT declares that fault and clears the other flag. Local takes priority if both sets appear in one word.
  - A declared fault clears after FAULT_CLEAR_COUNT consecutive words with no fault set.
  - rx_block_lock low: local_fault=0, remote_fault=0, all fault counters cleared.
- Link FSM states: DOWN, QUALIFY, UP.
  - DOWN -> QUALIFY when rx_block_lock=1 and no fault is declared; the qualify counter is cleared.
  - QUALIFY: counter increments each clean cycle. Loss of lock or a fault goes back to DOWN. Reaching LINK_UP_CYCLES-1 -> UP.
  - UP: link_up=1. Loss of lock or a fault declaration goes to DOWN, with link_up=0 on the next cycle.
- Frame FSM states: IDLE, IN_FRAME, with an errored flag.
  - IDLE + start -> IN_FRAME, errored=0. Terminate or error in IDLE is ignored.
  - IN_FRAME + error character -> errored=1.
  - IN_FRAME + terminate -> IDLE. frame_count++ if not errored; otherwise bad_frame_count++.
  - IN_FRAME + start without a prior terminate -> bad_frame_count++ and restart the frame.
  - Terminate in lanes 0-3 together with start in lane 4 in the same word: close the current frame first, then open the new one.
  - An error character in the same word as the terminate counts that frame as bad.
  - Loss of rx_block_lock while IN_FRAME -> bad_frame_count++ and return to IDLE.
- Counters: saturate at all-ones and never wrap. clear_counters zeroes all three; if an increment coincides with clear, clear wins and the result is 0.

Test Plan:
- Lock high with idles (0x0707070707070707, rxc=0xFF), LINK_UP_CYCLES=16 -> link_up rises exactly 17 cycles after lock; dropping lock -> link_up=0 on the next cycle.
- 4 consecutive local-fault words (rxd=0x0100009C_0100009C, rxc=0x11) -> local_fault=1, fault_event_count=1, link_up=0. Then 127 idle words -> still 1; 128th idle word -> 0.
- 3 remote-fault words, 1 idle, 3 remote-fault words -> remote_fault stays 0. Then 4 consecutive remote-fault words -> remote_fault=1 and local_fault=0.
- Three good frames (start lane 0, data, terminate lane 3), then one frame containing 0xFE -> frame_count=3, bad_frame_count=1.
- Word with terminate in lane 2 and start in lane 4, then a terminate -> frame_count +2. Start, start, terminate -> bad +1, good +1. Lock drop mid-frame -> bad +1.
- Force frame_count to all-ones, send a good frame -> stays 0xFFFFFFFF. Pulse clear_counters in the same cycle as a terminate -> all counters 0. Assert rst mid-frame -> outputs 0 immediately (asynchronous).
